booth_product_accumulator: RTL and testbench
============================================

// Module: booth_product_accumulator
// PURPOSE
//  Downstream stage of the sequential Booth multiplier. Takes each signed 2N-bit product
//  (prod_valid is wired to the multiplier's done pulse) and sums ACC_LEN products into a
//  guarded signed accumulator (one "frame"). Each finished frame is handed to a valid/ready
//  consumer through a one-deep output register.
//  in_ready tells the controller when it may issue the next multiplier load.
// PARAMETERS
//  N        32  multiplier operand width; product width is 2N
//  G        4   guard bits; accumulator width AW = 2N+G
//  ACC_LEN  16  products per frame, >= 1; counter width $clog2(ACC_LEN+1)
// PORTS
//  clk         in   1     clock; all state updates on rising edge
//  rst_n       in   1     asynchronous active-low reset
//  prod_valid  in   1     single-cycle product strobe
//  prod        in   2N    signed product, sampled when prod_valid=1
//  acc_clr     in   1     synchronous frame abort / clear
//  in_ready    out  1     1 = a product strobed this cycle will be accepted
//  out_valid   out  1     output register holds an unconsumed frame result
//  out_data    out  AW    signed frame sum
//  out_ovf     out  1     overflow occurred within this frame
//  out_ready   in   1     consumer accepts out_data when out_valid & out_ready
//  drop_err    out  1     sticky: a product arrived while in_ready=0
// BEHAVIOUR
//  Reset (async): state=ACCUM, acc=0, cnt=0, frame_ovf=0, out_valid=0, out_data=0,
//   out_ovf=0, drop_err=0. in_ready=1 once reset is released.
//  Accept: prod_valid & in_ready. The product is sign-extended to AW and added (two's
//   complement). acc updates on the next edge.
//  Overflow: compute the sum at AW+1 bits; top two bits differ -> overflow. This sets
//   frame_ovf.
//  States:
//   ACCUM: in_ready=1. When an accepted product makes cnt reach ACC_LEN ("last"):
//    - If the output register is empty, or is drained this same cycle:
//      out_data <= final sum; out_ovf <= final frame_ovf; out_valid <= 1;
//      acc <= 0; cnt <= 0; frame_ovf <= 0; stay in ACCUM.
//    - Otherwise: acc keeps the final sum; go to HOLD.
//   HOLD: in_ready=0. When out_valid & out_ready, transfer acc to the output register
//    (out_valid stays 1), clear acc, cnt and frame_ovf, then go to ACCUM.
//  Latency: last product accepted at edge t -> out_valid=1 after edge t+1 (1 cycle).
//  out_valid falls on the edge after out_valid & out_ready, unless it is refilled on that
//   same edge. While out_valid=1 and out_ready=0, out_data and out_ovf are held stable.
//  Drop: prod_valid while in_ready=0 -> product discarded, drop_err <= 1.
//   drop_err is cleared only by reset or acc_clr.
//  acc_clr (either state): acc <= 0, cnt <= 0, frame_ovf <= 0, drop_err <= 0, state=ACCUM.
//   The output register is untouched.
//   acc_clr together with prod_valid: the product becomes the first term
//   (acc <= sext(prod), cnt <= 1). If ACC_LEN=1, this term completes the frame normally.
//  ACC_LEN=1: every accepted product is a complete frame.
//  cnt never exceeds ACC_LEN. No wrap-around of cnt is permitted.
// CONFIGURATION
//  BOOTH_ACC_SAT_EN defined: on overflow, acc saturates to the AW-bit signed max or min,
//   chosen by the sign of the true sum. Once saturated, acc stays saturated in that
//   direction until the frame is emitted.
//  BOOTH_ACC_SAT_EN undefined: the sum wraps modulo 2^AW.
//  In both builds, frame_ovf and out_ovf are reported.
// TESTING
//  (N=8, G=4, ACC_LEN=4 unless stated)
//  T1 basic: products 100, 200, -50, 7 with out_ready=1 -> one out_valid pulse,
//     out_data=257, out_ovf=0, 1 cycle after the 4th strobe.
//  T2 backpressure: out_ready=0, 8 products of 1 -> frame1=4 held in the output
//     register, frame2 held in HOLD, in_ready=0. A 9th strobe -> drop_err=1.
//     Raise out_ready -> 4 then 4 delivered, in_ready returns to 1.
//  T3 overflow (N=8, G=0, ACC_LEN=4): four products of 16384 -> out_ovf=1.
//     out_data=0 (wrap) or 32767 (BOOTH_ACC_SAT_EN).
//  T4 clear: products 5, 6, then acc_clr coincident with product 9, then 1, 1, 1
//     -> out_data=12; drop_err cleared.
//  T5 drain-and-refill: out_valid=1, out_ready=1 in the same cycle the last product of the
//     next frame is accepted -> no HOLD entry, out_valid stays 1, new data the next cycle.
//  T6 reset mid-frame: assert rst_n=0 after 2 products -> all outputs at reset values
//     immediately. The next 4 products form a fresh frame.

Source files
------------

// File: rtl/booth_product_accumulator_if.sv
// Product-in / frame-out bus between the Booth multiplier controller, the
// frame accumulator and the downstream consumer of frame sums.
interface booth_product_accumulator_if #(
  parameter int N = 32,
  parameter int G = 4
);
  localparam int AW = 2 * N + G;

  logic                  prod_valid;
  logic signed [2*N-1:0] prod;
  logic                  acc_clr;
  logic                  in_ready;
  logic                  out_valid;
  logic signed [AW-1:0]  out_data;
  logic                  out_ovf;
  logic                  out_ready;
  logic                  drop_err;

  modport master (
    output prod_valid, prod, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, drop_err
  );

  modport slave (
    input  prod_valid, prod, acc_clr, out_ready,
    output in_ready, out_valid, out_data, out_ovf, drop_err
  );
endinterface

// File: rtl/booth_product_accumulator.sv
// Sums ACC_LEN signed Booth products per frame into a guarded accumulator and
// hands each frame to a one-deep output register. Optional: BOOTH_ACC_SAT_EN.
module booth_product_accumulator #(
  parameter int N       = 32,
  parameter int G       = 4,
  parameter int ACC_LEN = 16
) (
  input logic clk,
  input logic rst_n,
  booth_product_accumulator_if.slave bus
);
  localparam int AW = 2 * N + G;
  localparam int CW = $clog2(ACC_LEN + 1);
  localparam logic [CW-1:0] LEN = CW'(ACC_LEN);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 frame_ovf_q, frame_ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [AW-1:0] out_data_q, out_data_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 drop_err_q, drop_err_d;

  logic                 in_ready;
  logic                 accept, drop, drain, last;
  logic signed [AW-1:0] base_acc, prod_ext, sum_acc;
  logic [CW-1:0]        base_cnt, cnt_inc;
  logic                 base_ovf, step_ovf, sum_ovf;
  logic [AW:0]          sum_wide;
  logic                 load_sum, zero_frame;

  assign accept = bus.prod_valid & in_ready;
  assign drop   = bus.prod_valid & ~in_ready;
  assign drain  = out_valid_q & bus.out_ready;

  // acc_clr restarts the frame underneath a coincident product, so the product
  // is added onto zero rather than onto the aborted partial sum.
  always_comb begin : datapath
    base_acc = bus.acc_clr ? '0 : acc_q;
    base_cnt = bus.acc_clr ? '0 : cnt_q;
    base_ovf = ~bus.acc_clr & frame_ovf_q;
    prod_ext = AW'(bus.prod);
    sum_wide = {base_acc[AW-1], base_acc} + {prod_ext[AW-1], prod_ext};
    step_ovf = sum_wide[AW] ^ sum_wide[AW-1];
    sum_ovf  = base_ovf | step_ovf;
    cnt_inc  = base_cnt + CW'(1);
    last     = accept & (cnt_inc == LEN);
  end

`ifdef BOOTH_ACC_SAT_EN
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  logic sat_q, sat_d, base_sat;

  // Once pinned, the accumulator ignores further products until the frame ends.
  always_comb begin : saturate
    base_sat = ~bus.acc_clr & sat_q;
    if (base_sat) begin
      sum_acc = base_acc;
    end else if (step_ovf) begin
      sum_acc = sum_wide[AW] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_acc = sum_wide[AW-1:0];
    end
    sat_d = sat_q;
    if (load_sum) begin
      sat_d = base_sat | step_ovf;
    end else if (zero_frame) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`else
  assign sum_acc = sum_wide[AW-1:0];
`endif

  always_comb begin : next_state
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    frame_ovf_d = frame_ovf_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    drop_err_d  = (drop_err_q | drop) & ~bus.acc_clr;
    load_sum    = 1'b0;
    zero_frame  = 1'b0;

    if (bus.acc_clr) begin
      zero_frame = 1'b1;
      state_d    = ACCUM;
    end

    if (accept) begin
      if (last && (!out_valid_q || bus.out_ready)) begin
        out_data_d  = sum_acc;
        out_ovf_d   = sum_ovf;
        out_valid_d = 1'b1;
        zero_frame  = 1'b1;
      end else begin
        load_sum = 1'b1;
        if (last) begin
          state_d = HOLD;
        end
      end
    end else if (state_q == HOLD && drain && !bus.acc_clr) begin
      out_data_d  = acc_q;
      out_ovf_d   = frame_ovf_q;
      out_valid_d = 1'b1;
      zero_frame  = 1'b1;
      state_d     = ACCUM;
    end

    if (load_sum) begin
      acc_d       = sum_acc;
      cnt_d       = cnt_inc;
      frame_ovf_d = sum_ovf;
    end else if (zero_frame) begin
      acc_d       = '0;
      cnt_d       = '0;
      frame_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      frame_ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      frame_ovf_q <= frame_ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      drop_err_q  <= drop_err_d;
    end
  end

  always_comb begin : outputs
    in_ready = (state_q == ACCUM);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: directed vector table on a G=4 instance,
// overflow corner and randomized frame-queue reference model on a G=0 instance.
module tb_booth_product_accumulator;
  localparam int N       = 8;
  localparam int ACC_LEN = 4;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;
  localparam longint SPAN = 65536;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_product_accumulator_if #(.N(N), .G(4)) bus1 ();
  booth_product_accumulator_if #(.N(N), .G(0)) bus2 ();

  booth_product_accumulator #(.N(N), .G(4), .ACC_LEN(ACC_LEN)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  booth_product_accumulator #(.N(N), .G(0), .ACC_LEN(ACC_LEN)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct {
    logic               pv;
    logic signed [15:0] prod;
    logic               clr;
    logic               ordy;
    logic               e_ir;
    logic               e_ov;
    logic signed [19:0] e_data;
    logic               e_ovf;
    logic               e_drop;
  } vec_t;

  typedef struct {
    longint data;
    bit     ovf;
  } frame_t;

  vec_t   vecs[$];
  frame_t q[$];
  longint m_acc;
  int     m_cnt;
  bit     m_ovf, m_sat, m_drop;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void addv(int pv, int p, int clr, int ordy,
                               int ir, int ov, int d, int ovf, int dr);
    vec_t v;
    v.pv = 1'(pv); v.prod = 16'(p); v.clr = 1'(clr); v.ordy = 1'(ordy);
    v.e_ir = 1'(ir); v.e_ov = 1'(ov); v.e_data = 20'(d);
    v.e_ovf = 1'(ovf); v.e_drop = 1'(dr);
    vecs.push_back(v);
  endfunction

  task automatic idle_inputs();
    bus1.prod_valid = 1'b0; bus1.prod = '0; bus1.acc_clr = 1'b0; bus1.out_ready = 1'b0;
    bus2.prod_valid = 1'b0; bus2.prod = '0; bus2.acc_clr = 1'b0; bus2.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step1(input int pv, input int p, input int ordy);
    bus1.prod_valid = 1'(pv); bus1.prod = 16'(p); bus1.out_ready = 1'(ordy);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference frame arithmetic on the 16-bit (G=0) accumulator.
  function automatic void model_add(longint p);
    longint s = m_acc + p;
`ifdef BOOTH_ACC_SAT_EN
    if (!m_sat) begin
      if (s > MAXV || s < MINV) begin
        m_ovf = 1'b1; m_sat = 1'b1;
        m_acc = (s > 0) ? MAXV : MINV;
      end else begin
        m_acc = s;
      end
    end
`else
    if (s > MAXV) begin
      m_ovf = 1'b1; m_acc = s - SPAN;
    end else if (s < MINV) begin
      m_ovf = 1'b1; m_acc = s + SPAN;
    end else begin
      m_acc = s;
    end
`endif
  endfunction

  initial begin
    longint t3_exp;
    int     nframe;
    do_reset();
    #1;
    chk("rst_in_ready", longint'(bus1.in_ready), 1);
    chk("rst_out_valid", longint'(bus1.out_valid), 0);
    chk("rst_out_data", longint'(bus1.out_data), 0);
    chk("rst_out_ovf", longint'(bus1.out_ovf), 0);
    chk("rst_drop_err", longint'(bus1.drop_err), 0);
    chk("rst2_in_ready", longint'(bus2.in_ready), 1);
    chk("rst2_out_valid", longint'(bus2.out_valid), 0);

    // pv prod clr ordy | in_ready out_valid out_data out_ovf drop_err (after the edge)
    addv(1, 100, 0, 1,  1, 0, 0, 0, 0);
    addv(1, 200, 0, 1,  1, 0, 0, 0, 0);
    addv(1, -50, 0, 1,  1, 0, 0, 0, 0);
    addv(1,   7, 0, 1,  1, 1, 257, 0, 0);
    addv(0,   0, 0, 1,  1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addv(1, 1, 0, 0,  1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) addv(1, 1, 0, 0,  1, 1, 4, 0, 0);
    addv(1,   1, 0, 0,  0, 1, 4, 0, 0);
    addv(1,   1, 0, 0,  0, 1, 4, 0, 1);
    addv(0,   0, 0, 1,  1, 1, 4, 0, 1);
    addv(0,   0, 0, 1,  1, 0, 0, 0, 1);
    addv(1,   5, 0, 1,  1, 0, 0, 0, 1);
    addv(1,   6, 0, 1,  1, 0, 0, 0, 1);
    addv(1,   9, 1, 1,  1, 0, 0, 0, 0);
    addv(1,   1, 0, 1,  1, 0, 0, 0, 0);
    addv(1,   1, 0, 1,  1, 0, 0, 0, 0);
    addv(1,   1, 0, 1,  1, 1, 12, 0, 0);
    addv(0,   0, 0, 0,  1, 1, 12, 0, 0);
    addv(1,   2, 0, 0,  1, 1, 12, 0, 0);
    addv(1,   3, 0, 0,  1, 1, 12, 0, 0);
    addv(1,  -4, 0, 0,  1, 1, 12, 0, 0);
    addv(1,  10, 0, 1,  1, 1, 11, 0, 0);
    addv(0,   0, 0, 1,  1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addv(1, -32768, 0, 1,  1, 0, 0, 0, 0);
    addv(1, -32768, 0, 1,  1, 1, -131072, 0, 0);
    addv(0,   0, 0, 1,  1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus1.prod_valid = vecs[i].pv;
      bus1.prod       = vecs[i].prod;
      bus1.acc_clr    = vecs[i].clr;
      bus1.out_ready  = vecs[i].ordy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), longint'(bus1.in_ready), longint'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), longint'(bus1.out_valid), longint'(vecs[i].e_ov));
      chk($sformatf("vec%0d_drop_err", i), longint'(bus1.drop_err), longint'(vecs[i].e_drop));
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d_out_data", i), longint'(bus1.out_data), longint'(vecs[i].e_data));
        chk($sformatf("vec%0d_out_ovf", i), longint'(bus1.out_ovf), longint'(vecs[i].e_ovf));
      end
      $display("[TB] vec %0d pv=%0d prod=%0d clr=%0d ordy=%0d -> ir=%0d ov=%0d data=%0d ovf=%0d drop=%0d",
               i, vecs[i].pv, vecs[i].prod, vecs[i].clr, vecs[i].ordy, bus1.in_ready,
               bus1.out_valid, bus1.out_data, bus1.out_ovf, bus1.drop_err);
    end
    idle_inputs();

    // Overflow on the guard-less instance.
`ifdef BOOTH_ACC_SAT_EN
    t3_exp = 32767;
`else
    t3_exp = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      bus2.prod_valid = 1'b1; bus2.prod = 16'sd16384; bus2.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (k < 3) chk($sformatf("t3_early_valid%0d", k), longint'(bus2.out_valid), 0);
    end
    chk("t3_out_valid", longint'(bus2.out_valid), 1);
    chk("t3_out_data", longint'(bus2.out_data), t3_exp);
    chk("t3_out_ovf", longint'(bus2.out_ovf), 1);
    $display("[TB] t3 frame data=%0d ovf=%0d", bus2.out_data, bus2.out_ovf);
    bus2.prod_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t3_drained", longint'(bus2.out_valid), 0);
    idle_inputs();

    // Reset in the middle of a frame with a full output register.
    for (int k = 0; k < 4; k++) step1(1, 2, 0);
    step1(1, 5, 0);
    step1(1, 5, 0);
    chk("t6_pre_valid", longint'(bus1.out_valid), 1);
    chk("t6_pre_data", longint'(bus1.out_data), 8);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", longint'(bus1.out_valid), 0);
    chk("t6_rst_out_data", longint'(bus1.out_data), 0);
    chk("t6_rst_out_ovf", longint'(bus1.out_ovf), 0);
    chk("t6_rst_drop_err", longint'(bus1.drop_err), 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_in_ready", longint'(bus1.in_ready), 1);
    for (int k = 0; k < 4; k++) begin
      step1(1, 3, 1);
      if (k < 3) chk($sformatf("t6_early_valid%0d", k), longint'(bus1.out_valid), 0);
    end
    chk("t6_out_valid", longint'(bus1.out_valid), 1);
    chk("t6_out_data", longint'(bus1.out_data), 12);
    $display("[TB] t6 frame data=%0d", bus1.out_data);

    // Randomized traffic against a frame-queue model (output reg + one held frame).
    do_reset();
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_sat = 1'b0; m_drop = 1'b0;
    nframe = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic signed [15:0] ps;
      bit pv, clr, ordy, ir, cons;
      frame_t f;
      chk("rnd_in_ready", longint'(bus2.in_ready), longint'(q.size() < 2));
      chk("rnd_out_valid", longint'(bus2.out_valid), longint'(q.size() > 0));
      chk("rnd_drop_err", longint'(bus2.drop_err), longint'(m_drop));
      if (q.size() > 0) begin
        chk("rnd_out_data", longint'(bus2.out_data), q[0].data);
        chk("rnd_out_ovf", longint'(bus2.out_ovf), longint'(q[0].ovf));
      end
      pv   = ($urandom_range(0, 9) < 7);
      clr  = ($urandom_range(0, 31) == 0);
      ordy = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: ps = 16'($urandom);
        1: ps = 16'($urandom_range(16000, 32767));
        2: ps = 16'(-int'($urandom_range(16000, 32768)));
        default: ps = 16'(int'($urandom_range(0, 20)) - 10);
      endcase
      bus2.prod_valid = pv; bus2.prod = ps; bus2.acc_clr = clr; bus2.out_ready = ordy;

      ir   = (q.size() < 2);
      cons = (q.size() > 0) && ordy;
      if (clr) begin
        if (q.size() == 2) void'(q.pop_back());
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_sat = 1'b0; m_drop = 1'b0;
      end else if (pv && !ir) begin
        m_drop = 1'b1;
      end
      if (cons) begin
        f = q.pop_front();
        nframe++;
        $display("[TB] rnd frame %0d consumed data=%0d ovf=%0d", nframe, f.data, f.ovf);
      end
      if (pv && ir) begin
        model_add(longint'(ps));
        m_cnt++;
        if (m_cnt == ACC_LEN) begin
          f.data = m_acc; f.ovf = m_ovf;
          q.push_back(f);
          m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_sat = 1'b0;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
